// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Multi-cycle fetch/execute/commit sequencer. A word is fetched at PC,
//   held on `instruction` while the datapath decodes and executes it, and
//   PC advances at commit (PC+4, or PC+4+offset for a taken jump/branch).
//
// Ports
//   clk            clock, all state on rising edge
//   reset          synchronous active-high reset
//   imem_busywait  instruction memory busy (FETCH only)
//   imem_readdata  instruction word from instruction memory
//   busywait       data memory stall (COMMIT only)
//   branch_flag    current instruction is beq
//   jump_flag      current instruction is j
//   zero           ALU zero result
//   imem_read      instruction memory read request (FETCH, not in reset)
//   imem_address   fetch address, equal to pc
//   pc             program counter, word aligned
//   instruction    held instruction word
//   instr_valid    instruction holds a fetched, uncommitted word
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_busywait,
  input  logic [31:0] imem_readdata,
  input  logic        busywait,
  input  logic        branch_flag,
  input  logic        jump_flag,
  input  logic        zero,
  output logic        imem_read,
  output logic [31:0] imem_address,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        instr_valid
);

  typedef enum logic [1:0] {FETCH, EXEC, COMMIT} state_t;

  state_t      state;
  logic [31:0] offset;
  logic [31:0] next_pc;

  // Offset is already word scaled, so next_pc stays word aligned as long as
  // pc is. Jump and taken branch share one target, so no priority mux is
  // needed. An unknown flag falls through to the else arm (PC+4).
  always_comb begin
    offset  = {{22{instruction[23]}}, instruction[23:16], 2'b00};
    next_pc = pc + 32'd4;
    if (jump_flag || (branch_flag && zero))
      next_pc = pc + 32'd4 + offset;
  end

  assign imem_read    = (state == FETCH) && !reset;
  assign imem_address = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= 32'h0;
      instruction <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: if (!imem_busywait) begin
          instruction <= imem_readdata;
          instr_valid <= 1'b1;
          state       <= EXEC;
        end
        // one settle cycle for decode/ALU and for data memory to raise busywait
        EXEC: state <= COMMIT;
        COMMIT: if (!busywait) begin
          pc          <= next_pc;
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Transaction-level bench: each instruction is a planned sequence of
//   fetch stalls, one execute cycle and commit stalls. Inputs the unit must
//   ignore in a given phase are randomised. The reference keeps only the
//   architectural PC and the held instruction word.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_busywait;
  logic [31:0] imem_readdata;
  logic        busywait;
  logic        branch_flag;
  logic        jump_flag;
  logic        zero;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instr_valid;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_busywait (imem_busywait),
    .imem_readdata (imem_readdata),
    .busywait      (busywait),
    .branch_flag   (branch_flag),
    .jump_flag     (jump_flag),
    .zero          (zero),
    .imem_read     (imem_read),
    .imem_address  (imem_address),
    .pc            (pc),
    .instruction   (instruction),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // data-side inputs that only matter at the commit edge
  task automatic noise();
    busywait    = 1'($urandom);
    branch_flag = 1'($urandom);
    jump_flag   = 1'($urandom);
    zero        = 1'($urandom);
  endtask

  function automatic logic [31:0] mk_word(input logic [7:0] off);
    logic [31:0] w;
    w = $urandom;
    w[23:16] = off;
    return w;
  endfunction

  // one full instruction: f fetch stalls, exec, c commit stalls, commit
  task automatic run_instr(input int f, input int c, input logic [31:0] word,
                           input logic jf, input logic bf, input logic z);
    logic signed [7:0] o8;
    logic [31:0]       target;
    chk("fetch_rd", 32'(imem_read), 32'd1);
    chk("fetch_addr", imem_address, m_pc);
    for (int i = 0; i < f; i++) begin
      noise();
      imem_busywait = 1'b1;
      imem_readdata = $urandom;
      tick();
      chk("fstall_instr", instruction, m_instr);
      chk("fstall_vld", 32'(instr_valid), 32'd0);
      chk("fstall_pc", pc, m_pc);
      chk("fstall_rd", 32'(imem_read), 32'd1);
    end
    noise();
    imem_busywait = 1'b0;
    imem_readdata = word;
    tick();
    m_instr = word;
    chk("fetch_instr", instruction, word);
    chk("fetch_vld", 32'(instr_valid), 32'd1);
    chk("exec_rd", 32'(imem_read), 32'd0);
    // execute: everything ignored, busywait high here must not stall
    noise();
    busywait      = 1'b1;
    imem_busywait = 1'($urandom);
    imem_readdata = $urandom;
    tick();
    chk("exec_pc", pc, m_pc);
    chk("exec_vld", 32'(instr_valid), 32'd1);
    for (int i = 0; i < c; i++) begin
      noise();
      busywait      = 1'b1;
      imem_busywait = 1'($urandom);
      tick();
      chk("cstall_pc", pc, m_pc);
      chk("cstall_vld", 32'(instr_valid), 32'd1);
      chk("cstall_instr", instruction, word);
      chk("cstall_rd", 32'(imem_read), 32'd0);
    end
    busywait      = 1'b0;
    jump_flag     = jf;
    branch_flag   = bf;
    zero          = z;
    imem_busywait = 1'($urandom);
    tick();
    o8     = word[23:16];
    target = m_pc + 32'd4 + 32'(int'(o8) * 4);
    m_pc   = (jf || (bf && z)) ? target : m_pc + 32'd4;
    chk("commit_pc", pc, m_pc);
    chk("commit_vld", 32'(instr_valid), 32'd0);
    chk("commit_instr", instruction, word);
    chk("commit_align", 32'(pc[1:0]), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    noise();
    imem_busywait = 1'($urandom);
    imem_readdata = $urandom;
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_vld", 32'(instr_valid), 32'd0);
    chk("rst_rd", 32'(imem_read), 32'd0);
    reset   = 1'b0;
    m_pc    = 32'h0;
    m_instr = 32'h0;
    #1;
    chk("post_rst_rd", 32'(imem_read), 32'd1);
  endtask

  // reset landing in a fetch stall or a commit stall
  task automatic abort(input bit in_commit);
    noise();
    imem_busywait = 1'b1;
    tick();
    if (in_commit) begin
      imem_busywait = 1'b0;
      imem_readdata = $urandom;
      tick();
      busywait = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
        busywait = 1'b1;
        tick();
      end
      chk("abort_vld", 32'(instr_valid), 32'd1);
    end
    do_reset();
  endtask

  initial begin
    reset         = 1'b1;
    imem_busywait = 1'b0;
    imem_readdata = 32'h0;
    busywait      = 1'b0;
    branch_flag   = 1'b0;
    jump_flag     = 1'b0;
    zero          = 1'b0;
    m_pc          = 32'h0;
    m_instr       = 32'h0;
    tick();
    do_reset();

    // straight-line sequence 0x0 -> 0x4 -> 0x8 -> 0xC -> 0x10
    for (int i = 0; i < 4; i++) run_instr(0, 0, mk_word(8'($urandom)), 1'b0, 1'b0, 1'b0);
    chk("seq_pc10", pc, 32'h10);
    run_instr(0, 0, mk_word(8'hFF), 1'b1, 1'b0, 1'b0);   // self loop
    chk("self_loop", pc, 32'h10);
    run_instr(0, 0, mk_word(8'hFE), 1'b1, 1'b0, 1'b0);   // back one word
    chk("jump_back", pc, 32'h0C);
    run_instr(0, 0, mk_word(8'h04), 1'b1, 1'b0, 1'b0);   // to 0x20
    run_instr(0, 0, mk_word(8'h03), 1'b0, 1'b1, 1'b1);   // taken branch
    chk("beq_taken", pc, 32'h30);
    run_instr(0, 0, mk_word(8'hFA), 1'b1, 1'b0, 1'b0);   // 0x1C
    run_instr(0, 0, mk_word(8'h00), 1'b0, 1'b0, 1'b0);   // 0x20
    run_instr(0, 0, mk_word(8'h03), 1'b0, 1'b1, 1'b0);   // not taken
    chk("beq_not_taken", pc, 32'h24);
    run_instr(4, 5, mk_word(8'h10), 1'b0, 1'b0, 1'b0);   // long stalls
    run_instr(1, 2, mk_word(8'h02), 1'b1, 1'b1, 1'b0);   // jump wins over beq

    // wrap through the top of the address space
    do_reset();
    run_instr(0, 0, mk_word(8'hFE), 1'b1, 1'b0, 1'b0);
    chk("pc_top", pc, 32'hFFFFFFFC);
    run_instr(0, 0, mk_word(8'h00), 1'b0, 1'b0, 1'b0);
    chk("pc_wrap", pc, 32'h0);

    abort(1'b1);
    run_instr(0, 0, mk_word(8'h01), 1'b0, 1'b0, 1'b0);
    abort(1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset, sampled on rising edge of CLK.
REQ-003 IMEM_BUSYWAIT  input  1  instruction memory busy; low at a rising edge with IMEM_READ high means IMEM_READDATA is valid.
REQ-004 IMEM_READDATA  input  32  instruction word returned by instruction memory.
REQ-005 BUSYWAIT  input  1  data memory stall from the current load/store.
REQ-006 BRANCH_FLAG  input  1  decoded beq of the current INSTRUCTION.
REQ-007 JUMP_FLAG  input  1  decoded j of the current INSTRUCTION.
REQ-008 ZERO  input  1  ALU zero result for the current INSTRUCTION.
REQ-009 IMEM_READ  output  1  instruction memory read request.
REQ-010 IMEM_ADDRESS  output  32  byte address of the fetch; equals PC.
REQ-011 PC  output  32  program counter register, word aligned.
REQ-012 INSTRUCTION  output  32  held instruction word driven to the control unit, register file and ALU.
REQ-013 INSTR_VALID  output  1  high while INSTRUCTION holds a fetched, uncommitted instruction.

Function
REQ-014 State machine SHALL have three states: FETCH, EXEC, COMMIT; state register reset value FETCH.
REQ-015 IMEM_READ SHALL be high iff state is FETCH and RESET is low; IMEM_ADDRESS SHALL equal PC at all times.
REQ-016 FETCH: at each rising edge with IMEM_BUSYWAIT low, INSTRUCTION <= IMEM_READDATA, INSTR_VALID <= 1, state <= EXEC; with IMEM_BUSYWAIT high, all registers hold.
REQ-017 EXEC SHALL last exactly one cycle unconditionally (decode/ALU settle, data memory may raise BUSYWAIT), then state <= COMMIT.
REQ-018 COMMIT: at a rising edge with BUSYWAIT high, PC, INSTRUCTION, INSTR_VALID and state SHALL hold.
REQ-019 COMMIT with BUSYWAIT low: PC <= next-PC per REQ-020, INSTR_VALID <= 0, state <= FETCH; INSTRUCTION holds its value.
REQ-020 Next-PC: offset = INSTRUCTION[23:16] sign-extended to 32 bits and shifted left 2; if JUMP_FLAG, or BRANCH_FLAG and ZERO, next-PC = PC + 4 + offset; else PC + 4.
REQ-021 Arithmetic SHALL be 32-bit modulo 2^32; wrap-around at 0xFFFFFFFC -> 0x00000000 SHALL occur silently.
REQ-022 PC[1:0] SHALL always be 00.
REQ-023 JUMP_FLAG and BRANCH_FLAG both high: jump SHALL take precedence (target identical).
REQ-024 BRANCH_FLAG, JUMP_FLAG, ZERO and BUSYWAIT SHALL be ignored outside COMMIT; IMEM_BUSYWAIT SHALL be ignored outside FETCH.
REQ-025 X or Z on BRANCH_FLAG/JUMP_FLAG (undecoded opcode) SHALL be treated as 0; PC + 4 taken.
REQ-026 Minimum instruction period without stalls SHALL be 3 cycles (FETCH, EXEC, COMMIT).

Reset
REQ-027 RESET high at a rising edge SHALL force PC = 0x00000000, INSTRUCTION = 0x00000000, INSTR_VALID = 0, state = FETCH, in any state.
REQ-028 RESET SHALL override all other inputs, including mid-stall in FETCH or COMMIT; the pending fetch or commit is discarded.
REQ-029 First fetch after RESET deasserts SHALL read address 0x00000000.

Verification
REQ-030 Reset then IMEM_BUSYWAIT low, flags low -> PC sequence 0x0, 0x4, 0x8 with commits every 3 cycles; IMEM_READ high only in FETCH cycles.
REQ-031 COMMIT at PC=0x10, JUMP_FLAG=1, INSTRUCTION[23:16]=0xFE -> PC = 0x0C; offset 0xFF -> PC = 0x10 (self-loop).
REQ-032 COMMIT at PC=0x20, BRANCH_FLAG=1, offset 0x03: ZERO=1 -> PC = 0x30; ZERO=0 -> PC = 0x24.
REQ-033 IMEM_BUSYWAIT high 4 cycles in FETCH -> INSTRUCTION, PC unchanged, INSTR_VALID 0 until the edge after it falls; BUSYWAIT high 5 cycles in COMMIT -> PC and INSTRUCTION held, PC advances at first edge with BUSYWAIT low.
REQ-034 PC=0xFFFFFFFC, no branch -> next PC = 0x00000000; RESET asserted during a COMMIT stall -> PC = 0x0, INSTR_VALID = 0, next cycle IMEM_READ = 1.
